mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle CPU between two requesters: the CPU datapath (fetch and load/store states) and a program loader/debug port.
- Sits between both requesters and the memory.
- Serialises accesses, counts fixed memory latency, returns read data with a one-cycle ack pulse.
- The CPU controller holds its current state while cpu_ack is low.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, cycles from memory command to valid mem_rdata (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  AW  CPU address (IorD-selected PC or ALUOut)
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse to CPU
ld_req  in  1  loader access request, held until ld_ack
ld_we  in  1  loader write enable
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader write data
ld_rdata  out  DW  loader read data, registered
ld_ack  out  1  one-cycle completion pulse to loader
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_read  out  1  one-cycle read command
mem_write  out  1  one-cycle write command
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after command
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State to IDLE.
  - All outputs 0: acks, mem_read/mem_write, mem_addr/mem_wdata, cpu_rdata/ld_rdata, arb_busy.
  - Latency counter to 0; last_grant to LD, so the CPU wins the first tie.
  - Reset mid-transaction abandons it; no ack is ever issued for it.
- States: IDLE, CMD, WAIT, CAPT, ACK.
- IDLE:
  - Sample cpu_req/ld_req.
  - Only one high: grant it.
  - Both high: grant the port not equal to last_grant (round robin), then update last_grant.
  - On grant, register that port's addr/wdata/we into mem_addr/mem_wdata/cur_we, then go to CMD.
  - No request: stay in IDLE.
- CMD (exactly one cycle):
  - mem_read = ~cur_we, mem_write = cur_we.
  - Counter loads 1, next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - Leave when counter == MEM_LAT, i.e. the cycle in which mem_rdata is valid.
  - In that cycle, capture mem_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged), then go to CAPT.
  - MEM_LAT=1 gives exactly one WAIT cycle.
- CAPT: one cycle, then ACK. Makes rdata stable a full cycle before ack.
- ACK:
  - Assert the granted port's ack for exactly one cycle; the other ack stays 0.
  - Next state IDLE.
- Latency: request first seen in IDLE at cycle N.
  - Command at N+1.
  - Ack at N+MEM_LAT+3; with MEM_LAT=1, ack at N+4.
  - Writes take the same latency as reads.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Drop req in the cycle after ack. A req still high then is treated as a new request.
- Non-granted requests stay pending; their inputs are ignored until granted.
- rdata registers hold their value until that port's next read completes.
- mem_addr/mem_wdata hold their last value after the transaction.
- Only one transaction is ever outstanding.
- arb_busy = (state != IDLE).

Optional Feature:
- ARB_CPU_PRIORITY_EN defined:
  - Fixed priority; the CPU wins every tie in IDLE.
  - last_grant is still updated but unused. The loader may starve.
- Undefined: round robin as above.

Test Plan:
- Reset then cpu_req=1, cpu_we=0, cpu_addr=0x10, memory returns 0xDEADBEEF, MEM_LAT=1 -> mem_read pulses at N+1 with mem_addr=0x10; cpu_ack at N+4 with cpu_rdata=0xDEADBEEF; ld_ack stays 0.
- ld_req write addr 0x20, data 0x12345678 -> mem_write one cycle with mem_wdata=0x12345678; ld_ack at N+4; ld_rdata unchanged (0).
- cpu_req and ld_req both high from reset, each re-requesting after ack -> grants CPU, LD, CPU, LD. With ARB_CPU_PRIORITY_EN defined -> CPU every time.
- MEM_LAT=3, CPU read -> ack at N+6; mem_rdata sampled in the cycle counter==3.
- rst asserted during WAIT of a CPU read -> next cycle state IDLE, all outputs 0, no cpu_ack ever issued for that request.
- ld_req rises while the CPU transaction is in WAIT -> loader granted in the first IDLE cycle after the CPU's ACK; no mem command overlaps the CPU transaction.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU, loader and memory signal bundle for the memory port arbiter
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;

   logic          ld_req;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic [DW-1:0] ld_rdata;
   logic          ld_ack;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_rdata;

   logic          arb_busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      output ld_rdata, ld_ack,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata,
      output arb_busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output ld_req, ld_we, ld_addr, ld_wdata,
      input  ld_rdata, ld_ack,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata,
      input  arb_busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (CPU/loader) arbiter for a fixed-latency memory; ARB_CPU_PRIORITY_EN selects fixed CPU priority
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CMD  = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] CAPT = 3'd3;
   localparam logic [2:0] ACK  = 3'd4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LD  = 1'b1;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   logic [2:0] state;
   logic [3:0] latCnt;
   logic       lastGrant;
   logic       curPort;
   logic       curWe;
   logic       grantCpu;
   logic       grantLd;

   // Pick the winner among pending requests for the current IDLE cycle
   always_comb begin
      grantCpu = 1'b0;
      grantLd  = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
      grantCpu = bus.cpu_req;
`else
      grantCpu = bus.cpu_req & (~bus.ld_req | (lastGrant == PORT_LD));
`endif
      grantLd  = bus.ld_req & ~grantCpu;
   end

   assign bus.arb_busy = (state != IDLE);

   // Transaction sequencer: grant, command, latency count, capture, ack
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         latCnt        <= 4'd0;
         lastGrant     <= PORT_LD;
         curPort       <= PORT_CPU;
         curWe         <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.ld_rdata  <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.ld_ack    <= 1'b0;
      end else begin
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.cpu_ack   <= 1'b0;
         bus.ld_ack    <= 1'b0;
         case (state)
            IDLE: begin
               if (grantCpu) begin
                  curPort       <= PORT_CPU;
                  lastGrant     <= PORT_CPU;
                  curWe         <= bus.cpu_we;
                  bus.mem_addr  <= bus.cpu_addr;
                  bus.mem_wdata <= bus.cpu_wdata;
                  bus.mem_read  <= ~bus.cpu_we;
                  bus.mem_write <= bus.cpu_we;
                  state         <= CMD;
               end else if (grantLd) begin
                  curPort       <= PORT_LD;
                  lastGrant     <= PORT_LD;
                  curWe         <= bus.ld_we;
                  bus.mem_addr  <= bus.ld_addr;
                  bus.mem_wdata <= bus.ld_wdata;
                  bus.mem_read  <= ~bus.ld_we;
                  bus.mem_write <= bus.ld_we;
                  state         <= CMD;
               end
            end
            CMD: begin
               latCnt <= 4'd1;
               state  <= WAIT;
            end
            WAIT: begin
               if (latCnt == LAT) begin
                  if (!curWe) begin
                     if (curPort == PORT_CPU) bus.cpu_rdata <= bus.mem_rdata;
                     else                     bus.ld_rdata  <= bus.mem_rdata;
                  end
                  state <= CAPT;
               end else begin
                  latCnt <= latCnt + 4'd1;
               end
            end
            CAPT: begin
               if (curPort == PORT_CPU) bus.cpu_ack <= 1'b1;
               else                     bus.ld_ack  <= 1'b1;
               state <= ACK;
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [31:0] memData = 32'h0;
   logic [3:0]  mcnt1, mcnt3;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) b1 ();
   mem_port_arbiter_if #(.AW(32), .DW(32)) b3 ();

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

   // memory models: data valid only in the cycle MEM_LAT after the read command
   always @(posedge clk) begin
      if (rst) mcnt1 <= 4'd0;
      else if (b1.mem_read) mcnt1 <= 4'd1;
      else if (mcnt1 == 4'd1) mcnt1 <= 4'd0;
      else if (mcnt1 != 4'd0) mcnt1 <= mcnt1 + 4'd1;
   end
   always @(posedge clk) begin
      if (rst) mcnt3 <= 4'd0;
      else if (b3.mem_read) mcnt3 <= 4'd1;
      else if (mcnt3 == 4'd3) mcnt3 <= 4'd0;
      else if (mcnt3 != 4'd0) mcnt3 <= mcnt3 + 4'd1;
   end
   assign b1.mem_rdata = (mcnt1 == 4'd1) ? memData : 32'hBAD0BAD0;
   assign b3.mem_rdata = (mcnt3 == 4'd3) ? memData : 32'hBAD0BAD0;

   task automatic clear_inputs();
      b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h0; b1.cpu_wdata = 32'h0;
      b1.ld_req  = 1'b0; b1.ld_we  = 1'b0; b1.ld_addr  = 32'h0; b1.ld_wdata  = 32'h0;
      b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h0; b3.cpu_wdata = 32'h0;
      b3.ld_req  = 1'b0; b3.ld_we  = 1'b0; b3.ld_addr  = 32'h0; b3.ld_wdata  = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if ({b1.cpu_ack, b1.ld_ack, b1.mem_read, b1.mem_write, b1.arb_busy} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl got %b want 00000", {b1.cpu_ack, b1.ld_ack, b1.mem_read, b1.mem_write, b1.arb_busy});
      end
      total++;
      if ({b1.mem_addr, b1.mem_wdata} !== 64'h0) begin
         bad++; $display("FAIL reset_mem got %h/%h want 0/0", b1.mem_addr, b1.mem_wdata);
      end
      total++;
      if ({b1.cpu_rdata, b1.ld_rdata} !== 64'h0) begin
         bad++; $display("FAIL reset_rdata got %h/%h want 0/0", b1.cpu_rdata, b1.ld_rdata);
      end
      total++;
      if ({b3.cpu_ack, b3.arb_busy, b3.mem_read} !== 3'b0) begin
         bad++; $display("FAIL reset_lat3 got %b want 000", {b3.cpu_ack, b3.arb_busy, b3.mem_read});
      end
   endtask

   task automatic test_cpu_read();
      do_reset();
      memData = 32'hDEADBEEF;
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h10;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         total++;
         if (b1.mem_read !== (k == 1)) begin
            bad++; $display("FAIL cpu_read mem_read k=%0d got %b want %b", k, b1.mem_read, (k == 1));
         end
         total++;
         if (b1.cpu_ack !== (k == 4)) begin
            bad++; $display("FAIL cpu_read cpu_ack k=%0d got %b want %b", k, b1.cpu_ack, (k == 4));
         end
         total++;
         if (b1.ld_ack !== 1'b0) begin
            bad++; $display("FAIL cpu_read ld_ack k=%0d got %b want 0", k, b1.ld_ack);
         end
         if (k == 1) begin
            total++;
            if (b1.mem_addr !== 32'h10) begin
               bad++; $display("FAIL cpu_read mem_addr got %h want 00000010", b1.mem_addr);
            end
         end
         if (k == 4) begin
            total++;
            if (b1.cpu_rdata !== 32'hDEADBEEF) begin
               bad++; $display("FAIL cpu_read cpu_rdata got %h want deadbeef", b1.cpu_rdata);
            end
         end
         @(posedge clk); #1;
         if (k == 4) b1.cpu_req = 1'b0;
      end
   endtask

   task automatic test_ld_write();
      do_reset();
      memData = 32'hA5A5A5A5;
      b1.ld_req = 1'b1; b1.ld_we = 1'b1; b1.ld_addr = 32'h20; b1.ld_wdata = 32'h12345678;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         total++;
         if (b1.mem_write !== (k == 1)) begin
            bad++; $display("FAIL ld_write mem_write k=%0d got %b want %b", k, b1.mem_write, (k == 1));
         end
         total++;
         if (b1.mem_read !== 1'b0) begin
            bad++; $display("FAIL ld_write mem_read k=%0d got %b want 0", k, b1.mem_read);
         end
         total++;
         if (b1.ld_ack !== (k == 4) || b1.cpu_ack !== 1'b0) begin
            bad++; $display("FAIL ld_write acks k=%0d got ld=%b cpu=%b want ld=%b cpu=0", k, b1.ld_ack, b1.cpu_ack, (k == 4));
         end
         if (k == 1) begin
            total++;
            if (b1.mem_wdata !== 32'h12345678 || b1.mem_addr !== 32'h20) begin
               bad++; $display("FAIL ld_write mem_bus got %h@%h want 12345678@00000020", b1.mem_wdata, b1.mem_addr);
            end
         end
         if (k == 4) begin
            total++;
            if (b1.ld_rdata !== 32'h0) begin
               bad++; $display("FAIL ld_write ld_rdata got %h want 00000000", b1.ld_rdata);
            end
         end
         @(posedge clk); #1;
         if (k == 4) b1.ld_req = 1'b0;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] order;
      logic [3:0] expOrder;
      int n;
      do_reset();
      memData = 32'h0BADCAFE;
      order = 4'b0;
      n = 0;
`ifdef ARB_CPU_PRIORITY_EN
      expOrder = 4'b0000;
`else
      expOrder = 4'b1010;
`endif
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h100;
      b1.ld_req  = 1'b1; b1.ld_we  = 1'b0; b1.ld_addr  = 32'h200;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         if (b1.cpu_ack && b1.ld_ack) begin
            total++; bad++; $display("FAIL rr both_acks cycle=%0d got 11 want one", c);
         end
         if (b1.cpu_ack || b1.ld_ack) begin
            order[n] = b1.ld_ack;
            total++;
            if (b1.mem_addr !== (b1.ld_ack ? 32'h200 : 32'h100)) begin
               bad++; $display("FAIL rr mem_addr n=%0d got %h want %h", n, b1.mem_addr, (b1.ld_ack ? 32'h200 : 32'h100));
            end
            n++;
         end
      end
      total++;
      if (n != 4) begin
         bad++; $display("FAIL rr ack_count got %0d want 4", n);
      end
      total++;
      if (order !== expOrder) begin
         bad++; $display("FAIL rr grant_order got %b want %b (bit i = LD for grant i)", order, expOrder);
      end
      b1.cpu_req = 1'b0; b1.ld_req = 1'b0;
   endtask

   task automatic test_mem_lat3();
      do_reset();
      memData = 32'hCAFEF00D;
      b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h30;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         total++;
         if (b3.mem_read !== (k == 1)) begin
            bad++; $display("FAIL lat3 mem_read k=%0d got %b want %b", k, b3.mem_read, (k == 1));
         end
         total++;
         if (b3.cpu_ack !== (k == 6)) begin
            bad++; $display("FAIL lat3 cpu_ack k=%0d got %b want %b", k, b3.cpu_ack, (k == 6));
         end
         total++;
         if (b3.arb_busy !== (k >= 1 && k <= 6)) begin
            bad++; $display("FAIL lat3 arb_busy k=%0d got %b want %b", k, b3.arb_busy, (k >= 1 && k <= 6));
         end
         if (k == 6) begin
            total++;
            if (b3.cpu_rdata !== 32'hCAFEF00D) begin
               bad++; $display("FAIL lat3 cpu_rdata got %h want cafef00d", b3.cpu_rdata);
            end
         end
         @(posedge clk); #1;
         if (k == 6) b3.cpu_req = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic sawAck;
      memData = 32'h11112222;
      b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h40;
      for (int k = 0; k <= 3; k++) @(negedge clk);
      total++;
      if (b3.arb_busy !== 1'b1) begin
         bad++; $display("FAIL rst_mid busy_before got %b want 1", b3.arb_busy);
      end
      rst = 1'b1;
      b3.cpu_req = 1'b0;
      @(negedge clk);
      total++;
      if ({b3.arb_busy, b3.cpu_ack, b3.mem_read, b3.mem_write} !== 4'b0) begin
         bad++; $display("FAIL rst_mid ctrl got %b want 0000", {b3.arb_busy, b3.cpu_ack, b3.mem_read, b3.mem_write});
      end
      total++;
      if (b3.cpu_rdata !== 32'h0 || b3.mem_addr !== 32'h0) begin
         bad++; $display("FAIL rst_mid data got rdata=%h addr=%h want 0/0", b3.cpu_rdata, b3.mem_addr);
      end
      rst = 1'b0;
      sawAck = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (b3.cpu_ack) sawAck = 1'b1;
      end
      total++;
      if (sawAck !== 1'b0) begin
         bad++; $display("FAIL rst_mid late_ack got 1 want 0");
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      memData = 32'h55AA55AA;
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h50;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         total++;
         if (b1.mem_read !== (k == 1 || k == 6)) begin
            bad++; $display("FAIL b2b mem_read k=%0d got %b want %b", k, b1.mem_read, (k == 1 || k == 6));
         end
         total++;
         if (b1.cpu_ack !== (k == 4) || b1.ld_ack !== (k == 9)) begin
            bad++; $display("FAIL b2b acks k=%0d got cpu=%b ld=%b want cpu=%b ld=%b", k, b1.cpu_ack, b1.ld_ack, (k == 4), (k == 9));
         end
         if (k == 6) begin
            total++;
            if (b1.mem_addr !== 32'h60) begin
               bad++; $display("FAIL b2b ld_addr got %h want 00000060", b1.mem_addr);
            end
         end
         if (k == 9) begin
            total++;
            if (b1.ld_rdata !== 32'h55AA55AA) begin
               bad++; $display("FAIL b2b ld_rdata got %h want 55aa55aa", b1.ld_rdata);
            end
         end
         if (k == 2) begin
            b1.ld_req = 1'b1; b1.ld_we = 1'b0; b1.ld_addr = 32'h60;
         end
         @(posedge clk); #1;
         if (k == 4) b1.cpu_req = 1'b0;
         if (k == 9) b1.ld_req = 1'b0;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_cpu_read();
      test_ld_write();
      test_round_robin();
      test_mem_lat3();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
